// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder
//
// Serial frame receiver: start bit, DATA_WIDTH data bits LSB first, an
// optional parity bit, and one stop bit. Each bit lasts PRESCALE clocks and
// is decided by a 2-of-3 majority vote around the bit centre.
//
// Ports
//   CLK         rising-edge clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high, asynchronous to CLK
//   PAR_EN      1 = frame carries a parity bit before the stop bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      last accepted data word
//   DATA_VALID  one-cycle pulse when P_DATA updates
//   PAR_ERR     parity mismatch in the last completed frame
//   STP_ERR     stop bit sampled low in the last completed frame
//   busy        high whenever the FSM is not in IDLE
//   dbg_state   current FSM state, for observation only
//
// Build option
//   RX_PAR_ERR_DROP_EN  when defined, a frame with a parity error does not
//                       load P_DATA or pulse DATA_VALID (PAR_ERR still sets).
//
// Handshake: DATA_VALID is a strobe with no ready; the word in P_DATA is
// valid in the DATA_VALID cycle and holds until the next accepted frame.
module rx_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

`ifdef RX_PAR_ERR_DROP_EN
  localparam bit DROP_ON_PAR_ERR = 1'b1;
`else
  localparam bit DROP_ON_PAR_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  rx_s_q, rx_s_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic                  maj;
  logic                  exp_par;

  // Third vote is the live synchronized sample at the decision count.
  assign maj     = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign exp_par = par_typ_q ? ~(^shift_q) : ^shift_q;

  always_comb begin
    state_d      = state_q;
    sync1_d      = RX_IN;
    rx_s_d       = sync1_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (!rx_s_q) begin
        // The low sample seen here is count 0 of the start bit, so the
        // counter resumes at 1 on the next sample.
        state_d   = START;
        cnt_d     = CW'(1);
        bit_cnt_d = '0;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
      end
    end else begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_S0) s0_d = rx_s_q;
      if (cnt_q == CNT_S1) s1_d = rx_s_q;
      if (cnt_q == CNT_DEC) begin
        unique case (state_q)
          START: begin
            if (maj) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = DATA;
            end
          end
          DATA: begin
            shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
          end
          PARITY: begin
            if (maj != exp_par) par_err_d = 1'b1;
            state_d = STOP;
          end
          STOP: begin
            // Leave half a bit early so a back-to-back start edge is seen.
            state_d = IDLE;
            cnt_d   = '0;
            if (!maj) begin
              stp_err_d = 1'b1;
            end else if (!DROP_ON_PAR_ERR || !par_err_q) begin
              p_data_d     = shift_q;
              data_valid_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
module tb_rx_frame_decoder;

  localparam int W = 8;
  localparam int P = 8;

`ifdef RX_PAR_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         rx_in;
  logic         par_en;
  logic         par_typ;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_err;
  logic         stp_err;
  logic         busy;
  logic [2:0]   dbg_state;

  rx_frame_decoder #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];   // {word, par_err, stp_err}
  int vld_times[$];
  int vld_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_valid === 1'b1) begin
      logic [W+1:0] e;
      vld_cnt++;
      vld_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(p_data), 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", 32'(p_data), 32'(e[W+1:2]));
        check("sb_par_err", 32'(par_err), 32'(e[1]));
        check("sb_stp_err", 32'(stp_err), 32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; holds each bit for P edges.
  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (P) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pe,
                            input logic pbit, input logic sb);
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
    if (pe) drive_bit(pbit);
    drive_bit(sb);
    rx_in = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] d;
    logic         pe;
    logic         pt;
    logic         flip;     // 1 = send wrong parity bit
    logic         sb;       // stop bit value
    logic         exp_par;
    logic         exp_stp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  logic [W-1:0] last_word;

  initial begin
    int n;
    logic found;
    logic pbit;
    logic exp_valid;

    //          d      pe    pt    flip  sb    par   stp
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 8; i < NV; i++) begin
      vecs[i].d       = W'($urandom_range(0, 255));
      vecs[i].pe      = 1'($urandom_range(0, 1));
      vecs[i].pt      = 1'($urandom_range(0, 1));
      vecs[i].flip    = 1'($urandom_range(0, 1));
      vecs[i].sb      = ($urandom_range(0, 3) != 0);
      vecs[i].exp_par = vecs[i].pe & vecs[i].flip;
      vecs[i].exp_stp = ~vecs[i].sb;
    end

    rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    last_word = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_data", 32'(p_data), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_par_err", 32'(par_err), 0);
    check("rst_stp_err", 32'(stp_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // ---- table-driven frames ----
    for (int v = 0; v < NV; v++) begin
      par_en  = vecs[v].pe;
      par_typ = vecs[v].pt;
      pbit = (vecs[v].pt ? ~(^vecs[v].d) : ^vecs[v].d) ^ vecs[v].flip;
      exp_valid = vecs[v].sb && !(DROP && vecs[v].exp_par);
      if (exp_valid) begin
        exp_q.push_back({vecs[v].d, vecs[v].exp_par, vecs[v].exp_stp});
        last_word = vecs[v].d;
      end
      send_frame(vecs[v].d, vecs[v].pe, pbit, vecs[v].sb);
      // This negedge follows the stop-bit decision edge.
      @(negedge clk);
      check("vec_valid_slot", 32'(data_valid), 32'(exp_valid));
      check("vec_par_err", 32'(par_err), 32'(vecs[v].exp_par));
      check("vec_stp_err", 32'(stp_err), 32'(vecs[v].exp_stp));
      check("vec_busy_after_stop", 32'(busy), 0);
      check("vec_p_data", 32'(p_data), 32'(last_word));
      @(negedge clk);
      check("vec_valid_one_cycle", 32'(data_valid), 0);
      repeat (24) @(posedge clk);
      #1;
      check("vec_p_data_hold", 32'(p_data), 32'(last_word));
      check("vec_idle_busy", 32'(busy), 0);
    end

    // ---- back-to-back frames, no idle gap ----
    par_en = 1'b0;
    vld_times.delete();
    exp_q.push_back({8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'hFE, 1'b0, 1'b0});
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    last_word = 8'hFE;
    check("b2b_pulses", 32'(vld_times.size()), 2);
    if (vld_times.size() == 2)
      check("b2b_spacing", 32'(vld_times[1] - vld_times[0]), 80);
    check("b2b_word", 32'(p_data), 32'h00FE);
    @(posedge clk);
    #1;

    // ---- false start: line low for 2 cycles ----
    n = vld_cnt;
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    begin
      int hi = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy) hi++;
      end
      check("false_start_busy_cycles", 32'(hi), 32'(P / 2 + 1));
    end
    check("false_start_busy_end", 32'(busy), 0);
    check("false_start_no_valid", 32'(vld_cnt), 32'(n));
    check("false_start_par_err", 32'(par_err), 0);
    check("false_start_stp_err", 32'(stp_err), 0);
    check("false_start_p_data", 32'(p_data), 32'(last_word));
    @(posedge clk);
    #1;

    // ---- break: line held low ----
    n = vld_cnt;
    rx_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge clk);
      if (stp_err) found = 1'b1;
    end
    check("break_stp_err", 32'(found), 1);
    check("break_idle_at_decision", 32'(busy), 0);
    @(negedge clk);
    check("break_restart_busy", 32'(busy), 1);
    check("break_restart_clear", 32'(stp_err), 0);
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge clk);
      if (stp_err) found = 1'b1;
    end
    check("break_repeat_stp_err", 32'(found), 1);
    rx_in = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("break_end_busy", 32'(busy), 0);
    check("break_no_valid", 32'(vld_cnt), 32'(n));
    check("break_p_data", 32'(p_data), 32'(last_word));

    // ---- reset in the middle of a frame ----
    n = vld_cnt;
    par_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_p_data", 32'(p_data), 0);
    check("midrst_valid", 32'(data_valid), 0);
    check("midrst_par_err", 32'(par_err), 0);
    check("midrst_stp_err", 32'(stp_err), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("postrst_busy", 32'(busy), 0);
    check("postrst_p_data", 32'(p_data), 0);
    check("postrst_no_valid", 32'(vld_cnt), 32'(n));
    check("postrst_stp_err", 32'(stp_err), 0);

    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_decoder.md
RX_FRAME_DECODER -- requirements
Module: rx_frame_decoder

Interface
REQ-001: Parameter DATA_WIDTH, default 8: number of data bits per frame, sent LSB first.
REQ-002: Parameter PRESCALE, default 8: CLK cycles per serial bit; SHALL be even and >= 4.
REQ-003: CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: RST  input  1  reset, asynchronous, active-low.
REQ-005: RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-006: PAR_EN  input  1  1 = frame carries a parity bit between the data bits and the stop bit.
REQ-007: PAR_TYP  input  1  0 = even parity (XOR of data), 1 = odd parity (XNOR of data).
REQ-008: P_DATA  output  DATA_WIDTH  last accepted data word.
REQ-009: DATA_VALID  output  1  one-cycle pulse when P_DATA updates.
REQ-010: PAR_ERR  output  1  parity mismatch in the last completed frame.
REQ-011: STP_ERR  output  1  stop bit sampled low in the last completed frame.
REQ-012: busy  output  1  high in every state except IDLE.

Function
REQ-013: RX_IN SHALL pass through a 2-flop synchronizer; rx_s is RX_IN delayed 2 cycles, and all decoding SHALL use rx_s.
REQ-014: The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015: In IDLE, rx_s == 0 SHALL enter START and clear the sample counter; that rx_s sample is counter value 0.
REQ-016: On entering START, PAR_EN and PAR_TYP SHALL be latched for the whole frame, and PAR_ERR and STP_ERR SHALL clear.
REQ-017: The counter SHALL run 0..PRESCALE-1 per bit and wrap to 0 at each bit boundary.
REQ-018: rx_s SHALL be sampled at counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, and the bit value SHALL be the 2-of-3 majority.
REQ-019: The bit SHALL be decided at count PRESCALE/2+1.
REQ-020: In START, a decided 1 is a false start and SHALL return the FSM to IDLE with no outputs changed except busy; a decided 0 SHALL lead to DATA.
REQ-021: DATA SHALL shift the decided bits in LSB first.
REQ-022: After DATA_WIDTH bits, DATA SHALL go to PARITY if the latched PAR_EN = 1, otherwise to STOP.
REQ-023: In PARITY, the decided bit SHALL be compared with the expected parity of the shifted word per the latched PAR_TYP; a mismatch SHALL set PAR_ERR.
REQ-024: In STOP, a decided 0 SHALL set STP_ERR.
REQ-025: At the stop-bit decision the FSM SHALL return to IDLE immediately, half a bit early, so the next start edge is caught without loss.
REQ-026: At the stop-bit decision with a stop bit of 1, P_DATA SHALL load the word and DATA_VALID SHALL pulse in the next cycle; with a stop bit of 0, neither SHALL change.
REQ-027: PAR_ERR and STP_ERR are registered; each SHALL become valid in the same cycle as the DATA_VALID slot and hold until the next START entry.
REQ-028: P_DATA SHALL hold its value between valid frames.
REQ-029: With stop bit index b = 1+DATA_WIDTH+PAR_EN and clock edge 0 being the first edge that samples RX_IN low, the decision edge SHALL be 2 + b*PRESCALE + PRESCALE/2 + 1.
REQ-030: RX_IN held low indefinitely (break) SHALL give STP_ERR = 1, then IDLE; the low line SHALL then restart START every frame period.

Reset
REQ-031: RST low SHALL immediately force: FSM to IDLE, counter 0, synchronizer flops 1, P_DATA 0, DATA_VALID 0, PAR_ERR 0, STP_ERR 0, busy 0.
REQ-032: This SHALL hold even mid-frame; no partial frame is reported after release.

Configuration
REQ-033: Macro RX_PAR_ERR_DROP_EN defined: a frame with PAR_ERR = 1 SHALL NOT update P_DATA or pulse DATA_VALID, while PAR_ERR SHALL still assert.
REQ-034: Macro RX_PAR_ERR_DROP_EN undefined: P_DATA loads and DATA_VALID pulses regardless of parity, and PAR_ERR flags the error alongside.

Verification (DATA_WIDTH=8, PRESCALE=8)
REQ-035: PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> after edge 87, P_DATA=0xA5, DATA_VALID high 1 cycle, PAR_ERR=0, STP_ERR=0.
REQ-036: PAR_EN=1, PAR_TYP=1, frame 0xA5 with parity 0 -> PAR_ERR=1; with the macro undefined DATA_VALID pulses with P_DATA=0xA5; with it defined there is no pulse and P_DATA is unchanged.
REQ-037: PAR_EN=0, frame 0x3C with stop 0 -> STP_ERR=1, no DATA_VALID, P_DATA keeps its previous value; after edge 79, busy=0.
REQ-038: RX_IN low for 2 cycles, then high -> busy rises, FSM returns to IDLE at the start-bit decision, no DATA_VALID, errors stay 0.
REQ-039: Back-to-back frames 0x01 then 0xFE (PAR_EN=0) with no idle gap -> two DATA_VALID pulses exactly 80 cycles apart, with the correct words.
REQ-040: RST asserted at edge 40 of a frame, released 3 cycles later, line idle -> all outputs 0, busy=0, no DATA_VALID afterwards.
